// File: rtl/demux_pkg.sv
// Shared types and defaults for the serial-to-parallel lane demultiplexer.
package demux_pkg;

    localparam int N_LANES_DEF = 8;

    typedef enum logic {
        IDLE    = 1'b0,
        COLLECT = 1'b1
    } state_e;

endpackage

// File: rtl/lane_dec_1x8.sv
// Lane write-enable decoder: binary lane index to one-hot, gated by the accept strobe.
// Purely combinational, no backpressure.
module lane_dec_1x8
    import demux_pkg::*;
#(
    parameter int N_LANES = N_LANES_DEF,
    parameter int SEL_W   = $clog2(N_LANES)
) (
    input  logic [SEL_W-1:0]   sel_i,
    input  logic               stb_i,
    output logic [N_LANES-1:0] wr_en_o
);

    always_comb begin
        wr_en_o = '0;
        if (stb_i) begin
            wr_en_o = N_LANES'(1) << sel_i;
        end
    end

endmodule

// File: rtl/demux_1x8_deser.sv
// Serial-to-parallel demux: LSB-first bits after SOF fill lanes 0..N-1, then load a one-entry holding register.
// Frame visible the cycle after its last bit; a frame completing into a full, non-draining register is dropped (sticky overflow).
module demux_1x8_deser
    import demux_pkg::*;
#(
    parameter  int N_LANES = N_LANES_DEF,
    localparam int SEL_W   = $clog2(N_LANES)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_bit,
    input  logic               in_valid,
    input  logic               in_sof,
    output logic [N_LANES-1:0] out_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [SEL_W-1:0]   lane_sel,
    output logic               framing_err,
    output logic               overflow,
    input  logic               ovf_clr
);

    localparam logic [SEL_W-1:0] LAST_LANE = SEL_W'(N_LANES - 1);

    state_e               state_q, state_d;
    logic [SEL_W-1:0]     lane_sel_q, lane_sel_d;
    logic [N_LANES-1:0]   lanes_q, lanes_d;
    logic [N_LANES-1:0]   out_data_q, out_data_d;
    logic                 out_valid_q, out_valid_d;
    logic                 ferr_q, ferr_d;
    logic                 ovf_q, ovf_d;

    logic                 sof_acc;
    logic                 wr_stb;
    logic [SEL_W-1:0]     wr_idx;
    logic [N_LANES-1:0]   wr_en;
    logic                 complete;
    logic                 load;

    assign sof_acc = in_valid & in_sof;

    always_comb begin
        state_d    = state_q;
        lane_sel_d = lane_sel_q;
        wr_stb     = 1'b0;
        wr_idx     = lane_sel_q;
        complete   = 1'b0;
        ferr_d     = 1'b0;
        case (state_q)
            IDLE: begin
                if (sof_acc) begin
                    wr_stb     = 1'b1;
                    wr_idx     = '0;
                    lane_sel_d = SEL_W'(1);
                    state_d    = COLLECT;
                end
            end
            COLLECT: begin
                // A new SOF restarts the frame at lane 0; the partial frame is abandoned.
                if (sof_acc) begin
                    wr_stb     = 1'b1;
                    wr_idx     = '0;
                    lane_sel_d = SEL_W'(1);
                    ferr_d     = 1'b1;
                end else if (in_valid) begin
                    wr_stb = 1'b1;
                    if (lane_sel_q == LAST_LANE) begin
                        complete   = 1'b1;
                        lane_sel_d = '0;
                        state_d    = IDLE;
                    end else begin
                        lane_sel_d = lane_sel_q + SEL_W'(1);
                    end
                end
            end
        endcase
    end

    lane_dec_1x8 #(
        .N_LANES (N_LANES),
        .SEL_W   (SEL_W)
    ) u_lane_dec (
        .sel_i   (wr_idx),
        .stb_i   (wr_stb),
        .wr_en_o (wr_en)
    );

    always_comb begin
        lanes_d = lanes_q;
        for (int k = 0; k < N_LANES; k++) begin
            if (wr_en[k]) begin
                lanes_d[k] = in_bit;
            end
        end
    end

    // lanes_d already carries the final bit, so the completed frame loads in the same edge.
    assign load        = complete & (~out_valid_q | out_ready);
    assign out_data_d  = load ? lanes_d : out_data_q;
    assign out_valid_d = load | (out_valid_q & ~out_ready);
    assign ovf_d       = (complete & out_valid_q & ~out_ready) | (ovf_q & ~ovf_clr);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            lane_sel_q  <= '0;
            lanes_q     <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            ferr_q      <= 1'b0;
            ovf_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            lane_sel_q  <= lane_sel_d;
            lanes_q     <= lanes_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            ferr_q      <= ferr_d;
            ovf_q       <= ovf_d;
        end
    end

    assign out_data    = out_data_q;
    assign out_valid   = out_valid_q;
    assign lane_sel    = lane_sel_q;
    assign framing_err = ferr_q;
    assign overflow    = ovf_q;

endmodule
